// File: rtl/dac_stream_sequencer_if.sv
// CSR write bus toward the DAC streamer plus the waveform source-memory read port.
interface dac_stream_sequencer_if #(
  parameter int unsigned BUS_WIDTH         = 32,
  parameter int unsigned DAC_ADDRESS_WIDTH = 14,
  parameter int unsigned DAC_DATA_WIDTH    = 16
);
  logic [DAC_ADDRESS_WIDTH-1:0] srcAddr;
  logic [DAC_DATA_WIDTH-1:0]    srcData;
  logic [BUS_WIDTH-1:0]         streamerCsr;
  logic [BUS_WIDTH-1:0]         sysGpioData;
  logic                         sysAddressStrobe;
  logic                         sysGpioStrobe;

  modport master (
    output srcAddr, sysGpioData, sysAddressStrobe, sysGpioStrobe,
    input  srcData, streamerCsr
  );

  modport slave (
    input  srcAddr, sysGpioData, sysAddressStrobe, sysGpioStrobe,
    output srcData, streamerCsr
  );
endinterface

// File: rtl/dac_stream_sequencer.sv
// Loads the DAC table, then starts and stops the streamer on heartbeat boundaries.
// Every output is decoded from the next state and registered, so it lines up with the state.
module dac_stream_sequencer #(
  parameter int unsigned BUS_WIDTH         = 32,
  parameter int unsigned DAC_ADDRESS_WIDTH = 14,
  parameter int unsigned DAC_DATA_WIDTH    = 16,
  parameter int unsigned HB_COUNT_WIDTH    = 16,
  parameter int unsigned SYNC_TIMEOUT      = 1024
) (
  input  logic                         sysClk,
  input  logic                         sysReset_n,
  input  logic                         cmdStart,
  input  logic                         cmdAbort,
  input  logic [DAC_ADDRESS_WIDTH:0]   cmdLength,
  input  logic [HB_COUNT_WIDTH-1:0]    cmdHbCount,
  input  logic                         hbMarker,
  dac_stream_sequencer_if.master       bus,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int unsigned IDX_W  = DAC_ADDRESS_WIDTH + 1;
  localparam int unsigned SYNC_W = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [BUS_WIDTH-1:0] RUN_SET   = {1'b1, {(BUS_WIDTH-2){1'b0}}, 1'b1};
  localparam logic [BUS_WIDTH-1:0] RUN_CLR   = {1'b1, {(BUS_WIDTH-1){1'b0}}};
  localparam logic [BUS_WIDTH-1:0] DATA_MASK = BUS_WIDTH'(32'h00FF_FFFF);
  localparam logic [SYNC_W-1:0]    SYNC_LAST = SYNC_W'(SYNC_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_RD,
    S_LOAD_ADDR,
    S_LOAD_DATA,
    S_ARM,
    S_START,
    S_WAIT_SYNC,
    S_RUN,
    S_STOP,
    S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d, idx_inc;
  logic [IDX_W-1:0]             len_q, len_d;
  logic [HB_COUNT_WIDTH-1:0]    hb_q, hb_d;
  logic [SYNC_W-1:0]            sync_q, sync_d;
  logic [DAC_ADDRESS_WIDTH-1:0] src_addr_q, src_addr_d;
  logic [BUS_WIDTH-1:0]         gpio_q, gpio_d;
  logic                         astb_q, astb_d;
  logic                         gstb_q, gstb_d;
  logic                         busy_d, done_d, err_d;
  logic                         abortable;
  logic                         unused_csr;

  assign idx_inc    = idx_q + IDX_W'(1);
  assign abortable  = !(state_q inside {S_IDLE, S_STOP, S_DONE});
  assign unused_csr = ^{bus.streamerCsr[BUS_WIDTH-1:2], bus.streamerCsr[0]};

  assign bus.srcAddr          = src_addr_q;
  assign bus.sysGpioData      = gpio_q;
  assign bus.sysAddressStrobe = astb_q;
  assign bus.sysGpioStrobe    = gstb_q;

  // State and registered outputs
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      hb_q       <= '0;
      sync_q     <= '0;
      src_addr_q <= '0;
      gpio_q     <= '0;
      astb_q     <= 1'b0;
      gstb_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      hb_q       <= hb_d;
      sync_q     <= sync_d;
      src_addr_q <= src_addr_d;
      gpio_q     <= gpio_d;
      astb_q     <= astb_d;
      gstb_q     <= gstb_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= err_d;
    end
  end

  // Next state, counters and next-cycle output decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    hb_d       = hb_q;
    sync_d     = sync_q;
    err_d      = error;
    src_addr_d = src_addr_q;
    gpio_d     = '0;
    astb_d     = 1'b0;
    gstb_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmdStart) begin
          len_d   = cmdLength;
          hb_d    = cmdHbCount;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = (cmdLength != '0) ? S_LOAD_RD : S_ARM;
        end
      end
      S_LOAD_RD:   state_d = S_LOAD_ADDR;
      S_LOAD_ADDR: state_d = S_LOAD_DATA;
      S_LOAD_DATA: begin
        idx_d   = idx_inc;
        state_d = (idx_inc < len_q) ? S_LOAD_RD : S_ARM;
      end
      S_ARM: begin
        if (hbMarker) state_d = S_START;
      end
      S_START: begin
        sync_d  = '0;
        state_d = S_WAIT_SYNC;
      end
      S_WAIT_SYNC: begin
        if (bus.streamerCsr[1]) begin
          state_d = S_RUN;
        end else if (sync_q == SYNC_LAST) begin
          err_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          sync_d = sync_q + SYNC_W'(1);
        end
      end
      // A zero count never reaches the expiry branch, so the run lasts until abort.
      S_RUN: begin
        if (hbMarker && (hb_q != '0)) begin
          hb_d = hb_q - HB_COUNT_WIDTH'(1);
          if (hb_q == HB_COUNT_WIDTH'(1)) state_d = S_STOP;
        end
      end
      S_STOP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (cmdAbort && abortable) begin
      state_d = S_STOP;
      err_d   = error;
    end

    // srcData arrives during LOAD_ADDR, one cycle after the address was presented.
    case (state_d)
      S_LOAD_RD: src_addr_d = DAC_ADDRESS_WIDTH'(idx_d);
      S_LOAD_ADDR: begin
        gpio_d = BUS_WIDTH'(idx_d);
        astb_d = 1'b1;
      end
      S_LOAD_DATA: begin
        gpio_d = BUS_WIDTH'(bus.srcData) & DATA_MASK;
        gstb_d = 1'b1;
      end
      S_START: begin
        gpio_d = RUN_SET;
        gstb_d = 1'b1;
      end
      S_STOP: begin
        gpio_d = RUN_CLR;
        gstb_d = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_dac_stream_sequencer.sv
// Directed bench for dac_stream_sequencer: cycle-exact checks of table writes, RUN set/clear,
// done/busy/error, abort, timeout and reset behaviour.
module tb_dac_stream_sequencer;

  localparam int unsigned BW   = 32;
  localparam int unsigned AW   = 14;
  localparam int unsigned DW   = 16;
  localparam int unsigned HW   = 16;
  localparam int unsigned STO  = 1024;
  localparam logic [31:0] RSET = 32'h8000_0001;
  localparam logic [31:0] RCLR = 32'h8000_0000;

  typedef struct {
    int         cyc;
    logic       astb;
    logic       gstb;
    logic [31:0] data;
  } wr_t;

  logic          sysClk = 1'b0;
  logic          sysReset_n;
  logic          cmdStart, cmdAbort, hbMarker, synced;
  logic [AW:0]   cmdLength;
  logic [HW-1:0] cmdHbCount;
  logic          busy, done, error;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  wr_t wr_q[$];
  int  done_q[$];

  dac_stream_sequencer_if #(.BUS_WIDTH(BW), .DAC_ADDRESS_WIDTH(AW), .DAC_DATA_WIDTH(DW)) bus ();

  dac_stream_sequencer #(
    .BUS_WIDTH(BW), .DAC_ADDRESS_WIDTH(AW), .DAC_DATA_WIDTH(DW),
    .HB_COUNT_WIDTH(HW), .SYNC_TIMEOUT(STO)
  ) dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n),
    .cmdStart(cmdStart), .cmdAbort(cmdAbort),
    .cmdLength(cmdLength), .cmdHbCount(cmdHbCount),
    .hbMarker(hbMarker), .bus(bus),
    .busy(busy), .done(done), .error(error)
  );

  always #5 sysClk = ~sysClk;
  always @(posedge sysClk) cyc <= cyc + 1;

  // Source memory with one cycle of read latency: word at address a holds a + 0x10.
  always @(posedge sysClk) bus.srcData <= 16'(bus.srcAddr) + 16'h0010;
  assign bus.streamerCsr = {30'b0, synced, 1'b0};

  always @(negedge sysClk) begin
    if (bus.sysAddressStrobe || bus.sysGpioStrobe)
      wr_q.push_back('{cyc, bus.sysAddressStrobe, bus.sysGpioStrobe, bus.sysGpioData});
    if (done) done_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic hb_pulse(input int c);
    wait_until(c);
    hbMarker = 1'b1;
    tick();
    hbMarker = 1'b0;
  endtask

  task automatic start_cmd(input logic [AW:0] len, input logic [HW-1:0] hb, output int t);
    cmdLength  = len;
    cmdHbCount = hb;
    cmdStart   = 1'b1;
    t = cyc;
    tick();
    cmdStart = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (bus.srcAddr !== 14'd0) begin errors++; $display("FAIL reset_srcaddr: got %h expected 0", bus.srcAddr); end
    checks++; if (bus.sysGpioData !== 32'd0) begin errors++; $display("FAIL reset_gpio: got %h expected 0", bus.sysGpioData); end
    checks++; if ({bus.sysAddressStrobe, bus.sysGpioStrobe} !== 2'b00) begin
      errors++; $display("FAIL reset_strobes: got %b%b expected 00", bus.sysAddressStrobe, bus.sysGpioStrobe); end
    sysReset_n = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_load_and_run();
    int t, h, n, base;
    wr_t exp[$];
    wr_t got;
    base = wr_q.size();
    synced = 1'b0;
    start_cmd(15'd4, 16'd2, t);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lr_busy_t1: got %b expected 1", busy); end
    checks++; if (bus.srcAddr !== 14'd0) begin errors++; $display("FAIL lr_srcaddr_t1: got %h expected 0", bus.srcAddr); end
    hb_pulse(t + 5);
    h = t + 15;
    hb_pulse(h);
    hb_pulse(h + 3);
    wait_until(h + 6);
    synced = 1'b1;
    hb_pulse(h + 10);
    hb_pulse(h + 14);
    wait_until(h + 16);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL lr_done: got %b expected 1", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL lr_error: got %b expected 0", error); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lr_busy_end: got %b expected 0", busy); end
    synced = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp.push_back('{t + 2 + 3 * i, 1'b1, 1'b0, 32'(i)});
      exp.push_back('{t + 3 + 3 * i, 1'b0, 1'b1, 32'h10 + 32'(i)});
    end
    exp.push_back('{h + 1, 1'b0, 1'b1, RSET});
    exp.push_back('{h + 15, 1'b0, 1'b1, RCLR});
    n = wr_q.size() - base;
    checks++; if (n !== exp.size()) begin errors++; $display("FAIL lr_write_count: got %0d expected %0d", n, exp.size()); end
    for (int i = 0; i < exp.size() && i < n; i++) begin
      got = wr_q[base + i];
      checks++;
      if (got.cyc !== exp[i].cyc || got.astb !== exp[i].astb || got.gstb !== exp[i].gstb || got.data !== exp[i].data) begin
        errors++;
        $display("FAIL lr_write%0d: got t+%0d a=%b g=%b d=%h expected t+%0d a=%b g=%b d=%h", i,
                 got.cyc - t, got.astb, got.gstb, got.data, exp[i].cyc - t, exp[i].astb, exp[i].gstb, exp[i].data);
      end
    end
  endtask

  task automatic test_sync_timeout();
    int t, w, base;
    base = wr_q.size();
    synced = 1'b0;
    start_cmd(15'd0, 16'd1, t);
    hb_pulse(t + 3);
    w = t + 5;
    wait_until(w + STO - 1);
    checks++; if ({error, bus.sysGpioStrobe} !== 2'b00) begin
      errors++; $display("FAIL to_early: got error=%b strobe=%b expected 0 0", error, bus.sysGpioStrobe); end
    tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error_rise: got %b expected 1", error); end
    checks++; if (bus.sysGpioStrobe !== 1'b1 || bus.sysGpioData !== RCLR) begin
      errors++; $display("FAIL to_stop_write: got strobe=%b d=%h expected 1 %h", bus.sysGpioStrobe, bus.sysGpioData, RCLR); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL to_done: got %b expected 1", done); end
    tick();
    tick();
    checks++; if ({busy, error} !== 2'b01) begin errors++; $display("FAIL to_sticky: got busy=%b error=%b expected 0 1", busy, error); end
    checks++; if (wr_q.size() - base !== 2) begin errors++; $display("FAIL to_write_count: got %0d expected 2", wr_q.size() - base); end
  endtask

  task automatic test_abort_mid_load();
    int t, n, base, dbase;
    wr_t exp[$];
    wr_t got;
    base  = wr_q.size();
    dbase = done_q.size();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ab_error_held: got %b expected 1", error); end
    start_cmd(15'd4, 16'd3, t);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL ab_error_clear: got %b expected 0", error); end
    wait_until(t + 7);
    cmdAbort = 1'b1;
    tick();
    cmdAbort = 1'b0;
    wait_until(t + 10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy_end: got %b expected 0", busy); end
    exp.push_back('{t + 2, 1'b1, 1'b0, 32'd0});
    exp.push_back('{t + 3, 1'b0, 1'b1, 32'h10});
    exp.push_back('{t + 5, 1'b1, 1'b0, 32'd1});
    exp.push_back('{t + 6, 1'b0, 1'b1, 32'h11});
    exp.push_back('{t + 8, 1'b0, 1'b1, RCLR});
    n = wr_q.size() - base;
    checks++; if (n !== exp.size()) begin errors++; $display("FAIL ab_write_count: got %0d expected %0d", n, exp.size()); end
    for (int i = 0; i < exp.size() && i < n; i++) begin
      got = wr_q[base + i];
      checks++;
      if (got.cyc !== exp[i].cyc || got.astb !== exp[i].astb || got.gstb !== exp[i].gstb || got.data !== exp[i].data) begin
        errors++;
        $display("FAIL ab_write%0d: got t+%0d a=%b g=%b d=%h expected t+%0d a=%b g=%b d=%h", i,
                 got.cyc - t, got.astb, got.gstb, got.data, exp[i].cyc - t, exp[i].astb, exp[i].gstb, exp[i].data);
      end
    end
    checks++;
    if (done_q.size() - dbase !== 1 || done_q[done_q.size() - 1] !== t + 9) begin
      errors++; $display("FAIL ab_done: got %0d pulses last at t+%0d expected 1 at t+9",
                         done_q.size() - dbase, done_q[done_q.size() - 1] - t);
    end
  endtask

  task automatic test_infinite_run();
    int t, t2, base;
    base = wr_q.size();
    synced = 1'b1;
    start_cmd(15'd0, 16'd0, t);
    hb_pulse(t + 2);
    for (int k = 0; k < 20; k++) begin
      hb_pulse(t + 6 + 2 * k);
      if (k == 7) start_cmd(15'd3, 16'd1, t2);
    end
    wait_until(t + 46);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL inf_still_busy: got %b expected 1", busy); end
    checks++; if (wr_q.size() - base !== 1) begin errors++; $display("FAIL inf_writes_in_run: got %0d expected 1", wr_q.size() - base); end
    wait_until(t + 47);
    cmdAbort = 1'b1;
    tick();
    checks++; if (bus.sysGpioStrobe !== 1'b1 || bus.sysGpioData !== RCLR) begin
      errors++; $display("FAIL inf_stop_write: got strobe=%b d=%h expected 1 %h", bus.sysGpioStrobe, bus.sysGpioData, RCLR); end
    tick();
    cmdAbort = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL inf_done: got %b expected 1", done); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inf_busy_end: got %b expected 0", busy); end
    checks++; if (wr_q.size() - base !== 2) begin errors++; $display("FAIL inf_write_count: got %0d expected 2", wr_q.size() - base); end
    synced = 1'b0;
  endtask

  task automatic test_cmd_edges();
    int t, base;
    base = wr_q.size();
    synced     = 1'b1;
    cmdLength  = 15'd0;
    cmdHbCount = 16'd1;
    cmdStart   = 1'b1;
    cmdAbort   = 1'b1;
    t = cyc;
    tick();
    cmdStart = 1'b0;
    cmdAbort = 1'b0;
    hbMarker = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL edge_busy: got %b expected 1", busy); end
    tick();
    hbMarker = 1'b0;
    checks++; if (bus.sysGpioStrobe !== 1'b1 || bus.sysAddressStrobe !== 1'b0 || bus.sysGpioData !== RSET) begin
      errors++; $display("FAIL edge_start_write: got g=%b a=%b d=%h expected 1 0 %h",
                         bus.sysGpioStrobe, bus.sysAddressStrobe, bus.sysGpioData, RSET); end
    hb_pulse(t + 6);
    wait_until(t + 7);
    checks++; if (bus.sysGpioStrobe !== 1'b1 || bus.sysGpioData !== RCLR) begin
      errors++; $display("FAIL edge_stop_write: got strobe=%b d=%h expected 1 %h", bus.sysGpioStrobe, bus.sysGpioData, RCLR); end
    wait_until(t + 9);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL edge_busy_end: got %b expected 0", busy); end
    checks++; if (wr_q.size() - base !== 2) begin errors++; $display("FAIL edge_write_count: got %0d expected 2", wr_q.size() - base); end
    synced = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int t, t2, base, dbase;
    base = wr_q.size();
    synced = 1'b1;
    start_cmd(15'd2, 16'd5, t);
    hb_pulse(t + 8);
    wait_until(t + 13);
    checks++; if (bus.srcAddr !== 14'd1) begin errors++; $display("FAIL rst_pre_srcaddr: got %h expected 1", bus.srcAddr); end
    #2;
    sysReset_n = 1'b0;
    #1;
    checks++; if ({busy, done, error, bus.sysAddressStrobe, bus.sysGpioStrobe} !== 5'b0) begin
      errors++; $display("FAIL rst_async_flags: got %b expected 00000",
                         {busy, done, error, bus.sysAddressStrobe, bus.sysGpioStrobe}); end
    checks++; if (bus.srcAddr !== 14'd0 || bus.sysGpioData !== 32'd0) begin
      errors++; $display("FAIL rst_async_data: got addr=%h d=%h expected 0 0", bus.srcAddr, bus.sysGpioData); end
    @(posedge sysClk);
    @(posedge sysClk);
    #1;
    sysReset_n = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: got busy=%b expected 0", busy); end
    checks++; if (wr_q.size() - base !== 5) begin errors++; $display("FAIL rst_no_stop: got %0d writes expected 5", wr_q.size() - base); end
    dbase = done_q.size();
    start_cmd(15'd1, 16'd1, t2);
    wait_until(t2 + 2);
    checks++; if (bus.sysAddressStrobe !== 1'b1 || bus.sysGpioData !== 32'd0) begin
      errors++; $display("FAIL rst_new_addr: got a=%b d=%h expected 1 0", bus.sysAddressStrobe, bus.sysGpioData); end
    tick();
    checks++; if (bus.sysGpioStrobe !== 1'b1 || bus.sysGpioData !== 32'h10) begin
      errors++; $display("FAIL rst_new_data: got g=%b d=%h expected 1 10", bus.sysGpioStrobe, bus.sysGpioData); end
    hb_pulse(t2 + 5);
    hb_pulse(t2 + 9);
    wait_until(t2 + 12);
    checks++; if (done_q.size() - dbase !== 1 || done_q[done_q.size() - 1] !== t2 + 11) begin
      errors++; $display("FAIL rst_new_done: got %0d pulses last at t+%0d expected 1 at t+11",
                         done_q.size() - dbase, done_q[done_q.size() - 1] - t2);
    end
    synced = 1'b0;
  endtask

  initial begin
    sysReset_n = 1'b0;
    cmdStart   = 1'b0;
    cmdAbort   = 1'b0;
    hbMarker   = 1'b0;
    synced     = 1'b0;
    cmdLength  = '0;
    cmdHbCount = '0;
    test_reset();
    test_load_and_run();
    test_sync_timeout();
    test_abort_mid_load();
    test_infinite_run();
    test_cmd_edges();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dac_stream_sequencer.md
# dac_stream_sequencer

Single-clock sequencer that drives the genericDACStreamer CSR write interface on `sysClk`. On one start command it:
- loads a DAC waveform table from a source memory,
- arms on a heartbeat,
- sets the streamer RUN bit and confirms SYNCED within a timeout,
- streams for a programmed number of heartbeats, then clears RUN.

It replaces host firmware sequencing so that run start and stop are heartbeat-aligned and deterministic.

## Interface
- `BUS_WIDTH`, 32, CSR data width.
- `DAC_ADDRESS_WIDTH`, 14, table address width.
- `DAC_DATA_WIDTH`, 16, table sample width.
- `HB_COUNT_WIDTH`, 16, width of the heartbeat run counter.
- `SYNC_TIMEOUT`, 1024, maximum number of `sysClk` cycles to wait for SYNCED.

- `sysClk`  in  1  sole clock.
- `sysReset_n`  in  1  asynchronous, active-low reset.
- `cmdStart`  in  1  one-cycle pulse that starts a sequence.
- `cmdAbort`  in  1  one-cycle pulse that aborts a sequence.
- `cmdLength`  in  DAC_ADDRESS_WIDTH+1  number of table entries to load; 0 skips the load.
- `cmdHbCount`  in  HB_COUNT_WIDTH  number of heartbeats to run; 0 runs until abort.
- `srcAddr`  out  DAC_ADDRESS_WIDTH  source memory read address; read latency is 1 cycle.
- `srcData`  in  DAC_DATA_WIDTH  source memory read data.
- `hbMarker`  in  1  heartbeat pulse, already synchronised to `sysClk`.
- `streamerCsr`  in  BUS_WIDTH  streamer status word: bit1 = SYNCED, bit0 = RUN.
- `sysGpioData`  out  BUS_WIDTH  CSR write data.
- `sysAddressStrobe`  out  1  table address write strobe.
- `sysGpioStrobe`  out  1  CSR write strobe.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE.
- `error`  out  1  sticky sync-timeout flag.

## Operation
**Command capture**
- `cmdStart` is accepted only in IDLE. On acceptance, `cmdLength`, `cmdHbCount` are latched and `error` is cleared.
- `cmdStart` while busy is ignored.
- `cmdAbort` in IDLE is ignored. If `cmdStart` and `cmdAbort` arrive together in IDLE, the start is accepted.

**States**
- IDLE.
- LOAD_RD: drive `srcAddr` = entry index.
- LOAD_ADDR: `sysGpioData` = index zero-extended; `sysAddressStrobe` = 1.
- LOAD_DATA: `sysGpioData` = {1'b0, 7'b0, 8'b0, srcData} (bit31 = 0 selects the table bank; data is masked to bits [23:0]); `sysGpioStrobe` = 1.
- Entry index increments after LOAD_DATA. Go to LOAD_RD while index < length, else ARM. Each entry costs exactly 3 cycles.
- ARM: wait for `hbMarker`, then go to START.
- START: one cycle with `sysGpioData` = 0x80000001, `sysGpioStrobe` = 1.
- WAIT_SYNC: go to RUN on `streamerCsr[1]` = 1. After SYNC_TIMEOUT cycles without it: set `error` and go to STOP.
- RUN: the heartbeat counter, loaded with `cmdHbCount`, decrements on each `hbMarker`. On the marker that makes it 0, go to STOP. A count of 0 never expires.
- STOP: one cycle with `sysGpioData` = 0x80000000, `sysGpioStrobe` = 1.
- DONE: one cycle with `done` = 1, then IDLE.

**Abort**
- `cmdAbort` from any state other than IDLE, STOP or DONE goes to STOP on the next cycle. The RUN=0 write is therefore always issued, even if RUN was never set.
- `cmdAbort` during STOP or DONE is ignored.

**Width rules and write constraints**
- `cmdLength` up to 2^DAC_ADDRESS_WIDTH is legal; the index counter is DAC_ADDRESS_WIDTH+1 bits wide.
- At most one strobe is asserted per cycle. Strobes are exactly one cycle wide and every strobe has its own write cycle.
- `hbMarker` pulses during LOAD, START and WAIT_SYNC are not counted.

## Timing
- All outputs are registered. The reset value of every output is 0, including `srcAddr`, `sysGpioData`, `busy`, `done` and `error`.
- Asserting `sysReset_n` mid-sequence returns to IDLE immediately and issues no STOP write. Software is responsible for clearing the streamer after reset.
- `cmdStart` in cycle t → `busy` = 1 in t+1.
  - With `cmdLength` > 0, LOAD_RD begins in t+1.
  - With `cmdLength` = 0, ARM begins in t+1.
- Load phase duration is 3·N cycles; the first `sysAddressStrobe` occurs in t+2.
- `hbMarker` in ARM at cycle h → START strobe in h+1.
- Final counted `hbMarker` at cycle m → STOP strobe in m+1, `done` in m+2, `busy` = 0 in m+3.
- Abort at cycle a → STOP strobe in a+1, `done` in a+2.
- Sync timeout: `error` rises in the same cycle the state enters STOP.

## Test plan
- **Load and run:** `cmdLength` = 4, `cmdHbCount` = 2, source data = index + 0x10, SYNCED asserted 5 cycles after START.
  - Expect address/data write pairs (0, 0x10) through (3, 0x13), 3 cycles per entry.
  - START write 0x80000001 one cycle after the first heartbeat in ARM.
  - STOP write 0x80000000 one cycle after the second counted heartbeat, then a `done` pulse; `error` = 0.
- **Sync timeout:** SYNCED held at 0 → STOP write exactly SYNC_TIMEOUT cycles after entering WAIT_SYNC; `error` = 1 and stays 1 until the next `cmdStart`.
- **Abort mid-load:** abort issued in entry 2 → no further table writes, STOP write on the next cycle, `done` on the cycle after.
- **Infinite run:** `cmdHbCount` = 0 with 20 heartbeats → stays in RUN; `cmdAbort` → STOP write.
- **Command edge cases:**
  - `cmdLength` = 0 → zero table writes; ARM is entered in t+1.
  - `cmdStart` while busy → no effect.
  - Simultaneous `cmdStart` + `cmdAbort` in IDLE → sequence starts.
- **Reset mid-RUN:** drive `sysReset_n` low → all outputs 0 asynchronously and no STOP strobe. After release, state is IDLE and a new `cmdStart` works normally.
